// File: rtl/alu_pkg.sv
// Shared ALU definitions: controller state encoding and operation codes.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } alu_state_e;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder cell, time-shared by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: latches operands on start, feeds one full_adder
// LSB first, and presents sum, carry-out and signed overflow with a one-cycle done pulse.
module serial_add_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB_CIN = CNT_W'((WIDTH > 1) ? (WIDTH - 2) : 0);

    alu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             msb_cin_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .cout (fa_cout),
        .sum  (fa_sum)
    );

    // New sum bit enters at the MSB so the LSB computed first ends up at bit 0.
    if (WIDTH == 1) begin : g_shift_w1
        assign shift_d = fa_sum;
    end else begin : g_shift_wn
        assign shift_d = {fa_sum, shift_q[WIDTH-1:1]};
    end

    // Controller FSM with operand/result datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            shift_q   <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q       <= a;
                        b_q       <= (op_sub == ALU_OP_SUB) ? ~b : b;
                        carry_q   <= op_sub;
                        // For a single-bit operand the carry into the MSB is the initial carry.
                        msb_cin_q <= op_sub;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1'b1;
                    b_q     <= b_q >> 1'b1;
                    shift_q <= shift_d;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if ((WIDTH > 1) && (cnt_q == CNT_MSB_CIN)) begin
                        msb_cin_q <= fa_cout;
                    end else begin
                        msb_cin_q <= msb_cin_q;
                    end
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= shift_d;
                        cout_q  <= fa_cout;
                        ovf_q   <= msb_cin_q ^ fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table, scoreboard queue, corner sequences,
// a WIDTH=1 exhaustive sweep and random add/sub traffic.
module tb_serial_add_ctrl;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       start1, sub1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   start_cnt = 0;
    int   busy_cycles = 0;
    exp_t sb_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op_sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: two's complement add/sub of the low w bits, overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                   input logic sub);
        int   mask, bb, t;
        logic sa, sb, ss;
        exp_t e;
        mask   = (1 << w) - 1;
        bb     = sub ? ((~int'(b)) & mask) : (int'(b) & mask);
        t      = (int'(a) & mask) + bb + (sub ? 1 : 0);
        e.sum  = 8'(t & mask);
        e.cout = ((t >> w) & 1) != 0;
        sa     = a[w-1];
        sb     = b[w-1];
        ss     = e.sum[w-1];
        e.ovf  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        return e;
    endfunction

    // Scoreboard side: pop and compare on every done pulse of the 8-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cycles = 0;
        end else begin
            if (busy8) busy_cycles++;
            if (done8) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result{sum,cout,ovf}", {22'd0, sum8, cout8, ovf8},
                          {22'd0, e.sum, e.cout, e.ovf});
                    check("busy_cycles", busy_cycles, 32'd8);
                end
                busy_cycles = 0;
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 40 && done_cnt != start_cnt; i++) @(posedge clk);
        if (done_cnt != start_cnt) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got %0d done pulses, expected %0d", done_cnt, start_cnt);
            start_cnt = done_cnt;
            sb_q.delete();
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub, input exp_t e);
        @(negedge clk);
        a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
        sb_q.push_back(e);
        start_cnt++;
        @(negedge clk);
        start8 = 1'b0;
        wait_done();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        int         saved;
        logic [7:0] ra, rb;
        logic       rs;

        vecs[0] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        rst_n = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start1 = 1'b0; sub1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        #2;
        check("reset_outputs8", {23'd0, busy8, done8, sum8, cout8, ovf8}, 32'd0);
        check("reset_outputs1", {27'd0, busy1, done1, sum1, cout1, ovf1}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e = '{vecs[i].sum, vecs[i].cout, vecs[i].ovf};
            op8(vecs[i].a, vecs[i].b, vecs[i].sub, e);
        end

        // start held high with changing operands during RUN: one result per accepted start.
        saved = done_cnt;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
        sb_q.push_back(model(8, 8'h12, 8'h34, 1'b0));
        start_cnt++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        end
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h3C; sub8 = 1'b1;
        sb_q.push_back(model(8, 8'hC3, 8'h3C, 1'b1));
        start_cnt++;
        @(posedge clk); #1;
        check("held_start_done_width", {30'd0, done8, busy8}, 32'd0);
        @(posedge clk); #1;
        check("held_start_restart_busy", {31'd0, busy8}, 32'd1);
        @(negedge clk);
        start8 = 1'b0;
        wait_done();
        check("held_start_done_pulses", done_cnt - saved, 32'd2);

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h0F; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {23'd0, busy8, done8, sum8, cout8, ovf8}, 32'd0);
        saved = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt, saved);
        op8(8'h3A, 8'h5C, 1'b0, model(8, 8'h3A, 8'h5C, 1'b0));

        // WIDTH=1: every combination of a, b and op_sub (the initial carry).
        for (int i = 0; i < 8; i++) begin
            exp_t       e;
            logic [2:0] v;
            v = 3'(i);
            e = model(1, {7'd0, v[2]}, {7'd0, v[1]}, v[0]);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; sub1 = v[0]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            check("w1_busy", {31'd0, busy1}, 32'd1);
            @(negedge clk);
            check("w1_result{done,sum,cout,ovf}", {28'd0, done1, sum1, cout1, ovf1},
                  {28'd0, 1'b1, e.sum[0], e.cout, e.ovf});
            @(negedge clk);
            check("w1_done_low", {31'd0, done1}, 32'd0);
        end

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            op8(ra, rb, rs, model(8, ra, rb, rs));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
